// File: rtl/adder_seq_pkg.sv
// Shared types and helpers for the multi-cycle chunked adder.
// Imported by adder_seq and adder_chunk.
package adder_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational ripple of CHUNK full-adder cells.
// Exposes carry into the top bit for overflow detection.
module adder_chunk
  import adder_seq_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/adder_seq.sv
// Multi-cycle add/sub/accumulate unit, CHUNK bits per cycle
// with a registered ripple carry and valid/ready on both sides.
module adder_seq
  import adder_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("adder_seq: WIDTH must be a multiple of CHUNK");
  end

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              c_q, c_d;
  logic [WIDTH-1:0]  s_q, s_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic [WIDTH-1:0]  acc_q, acc_d;

  logic [CHUNK-1:0]  ch_s;
  logic              ch_cout;
  logic              ch_msb;

  // Operands shift right so the active chunk is always the low slice
  adder_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a     (a_q[CHUNK-1:0]),
    .b     (b_q[CHUNK-1:0]),
    .cin   (c_q),
    .s     (ch_s),
    .cout  (ch_cout),
    .c_msb (ch_msb)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    acc_d   = acc_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = acc ? acc_q : a;
          b_d     = sub ? ~b : b;
          c_d     = sub ? ~cin : cin;
          idx_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        a_d = a_q >> CHUNK;
        b_d = b_q >> CHUNK;
        c_d = ch_cout;
        s_d[idx_q*CHUNK +: CHUNK] = ch_s;
        if (idx_q == LAST) begin
          cout_d  = ch_cout;
          ovf_d   = ch_msb ^ ch_cout;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          acc_d   = s_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      acc_q   <= acc_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign s         = s_q;
  assign cout      = out_valid & cout_q;
  assign ovf       = out_valid & ovf_q;

endmodule

// File: tb/tb_adder_seq.sv
// Scoreboard bench for adder_seq (WIDTH=16, CHUNK=4).
// Expected results come from a plain integer model.
module tb_adder_seq;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         acc = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] s;
  logic         cout;
  logic         ovf;

  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] acc_m = '0;
  exp_t         sb[$];

  adder_seq #(.WIDTH(16), .CHUNK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .acc       (acc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                 input logic ci, input logic sb_, input logic ac);
    exp_t e;
    logic [W-1:0] opa, opb;
    logic         c0;
    logic [W:0]   full;
    logic [W-1:0] low;
    opa  = ac ? acc_m : aa;
    opb  = sb_ ? ~bb : bb;
    c0   = sb_ ? ~ci : ci;
    full = {1'b0, opa} + {1'b0, opb} + {{W{1'b0}}, c0};
    low  = {1'b0, opa[W-2:0]} + {1'b0, opb[W-2:0]} + {{(W-1){1'b0}}, c0};
    e.s  = full[W-1:0];
    e.co = full[W];
    e.ov = low[W-1] ^ full[W];
    return e;
  endfunction

  task automatic drive(input logic [W-1:0] aa, input logic [W-1:0] bb,
                       input logic ci, input logic sb_, input logic ac);
    a = aa; b = bb; cin = ci; sub = sb_; acc = ac;
    in_valid = 1'b1;
  endtask

  task automatic send(input logic [W-1:0] aa, input logic [W-1:0] bb,
                      input logic ci, input logic sb_, input logic ac,
                      output bit ok);
    int n;
    @(negedge clk);
    drive(aa, bb, ci, sb_, ac);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    sb.push_back(model(aa, bb, ci, sb_, ac));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (1) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) break;
      if (lat > 50) begin
        lat = -1;
        break;
      end
    end
  endtask

  task automatic consume(input logic [W-1:0] sv);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    acc_m = sv;
  endtask

  task automatic do_op(input logic [W-1:0] aa, input logic [W-1:0] bb,
                       input logic ci, input logic sb_, input logic ac,
                       output int lat);
    bit ok;
    send(aa, bb, ci, sb_, ac, ok);
    if (!ok) lat = -1;
    else wait_out(lat);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, s, cout, ovf} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: rdy=%b vld=%b s=%h co=%b ov=%b required 1 0 0000 0 0",
               in_ready, out_valid, s, cout, ovf);
    end
    rst = 1'b1;
    acc_m = '0;
    @(negedge clk);
  endtask

  task automatic test_add();
    logic [W-1:0] ta[3] = '{16'h00FF, 16'hFFFF, 16'h7FFF};
    logic [W-1:0] tb[3] = '{16'h0001, 16'h0001, 16'h0001};
    exp_t e;
    int   lat;
    for (int i = 0; i < 3; i++) begin
      do_op(ta[i], tb[i], 1'b0, 1'b0, 1'b0, lat);
      checks++;
      if (lat !== 4) begin
        errors++;
        $display("FAIL add_latency[%0d]: got %0d required 4", i, lat);
      end
      e = sb.pop_front();
      checks++;
      if ({s, cout, ovf} !== {e.s, e.co, e.ov}) begin
        errors++;
        $display("FAIL add[%0d]: s=%h co=%b ov=%b required s=%h co=%b ov=%b",
                 i, s, cout, ovf, e.s, e.co, e.ov);
      end
      consume(e.s);
    end
  endtask

  task automatic test_sub();
    logic [W-1:0] ta[3] = '{16'h0005, 16'h8000, 16'h0005};
    logic [W-1:0] tb[3] = '{16'h0007, 16'h0001, 16'h0002};
    logic         tc[3] = '{1'b0, 1'b0, 1'b1};
    exp_t e;
    int   lat;
    for (int i = 0; i < 3; i++) begin
      do_op(ta[i], tb[i], tc[i], 1'b1, 1'b0, lat);
      e = sb.pop_front();
      checks++;
      if (lat < 0 || {s, cout, ovf} !== {e.s, e.co, e.ov}) begin
        errors++;
        $display("FAIL sub[%0d]: lat=%0d s=%h co=%b ov=%b required s=%h co=%b ov=%b",
                 i, lat, s, cout, ovf, e.s, e.co, e.ov);
      end
      consume(e.s);
    end
  endtask

  task automatic test_acc();
    exp_t e;
    int   lat;
    test_reset();
    for (int i = 0; i < 4; i++) begin
      if (i < 3) do_op(16'hDEAD, 16'h0010, 1'b0, 1'b0, 1'b1, lat);
      else       do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, lat);
      e = sb.pop_front();
      checks++;
      if (lat < 0 || s !== e.s) begin
        errors++;
        $display("FAIL acc[%0d]: lat=%0d s=%h required %h", i, lat, s, e.s);
      end
      consume(e.s);
    end
  endtask

  task automatic test_backpressure();
    exp_t e, e2;
    int   lat;
    int   n;
    do_op(16'h1234, 16'h1111, 1'b1, 1'b0, 1'b0, lat);
    e = sb[0];
    drive(16'h0002, 16'h0003, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, s, cout, ovf} !== {1'b1, 1'b0, e.s, e.co, e.ov}) begin
        errors++;
        $display("FAIL hold[%0d]: vld=%b rdy=%b s=%h co=%b ov=%b required 1 0 %h %b %b",
                 i, out_valid, in_ready, s, cout, ovf, e.s, e.co, e.ov);
      end
    end
    void'(sb.pop_front());
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    acc_m = e.s;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL release: rdy=%b vld=%b required 1 0", in_ready, out_valid);
    end
    sb.push_back(model(16'h0002, 16'h0003, 1'b0, 1'b0, 1'b0));
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_out(lat);
    e2 = sb.pop_front();
    n = lat;
    checks++;
    if (n != 4 || s !== e2.s) begin
      errors++;
      $display("FAIL after_hold: lat=%0d s=%h required lat=4 s=%h", n, s, e2.s);
    end
    consume(e2.s);
  endtask

  task automatic test_abort();
    exp_t e;
    int   lat;
    bit   ok;
    send(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, ok);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    sb.delete();
    acc_m = '0;
    checks++;
    if ({out_valid, in_ready, s} !== {1'b0, 1'b1, 16'h0}) begin
      errors++;
      $display("FAIL abort: vld=%b rdy=%b s=%h required 0 1 0000", out_valid, in_ready, s);
    end
    @(negedge clk);
    rst = 1'b1;
    do_op(16'hAAAA, 16'h0005, 1'b0, 1'b0, 1'b1, lat);
    e = sb.pop_front();
    checks++;
    if (lat < 0 || s !== e.s) begin
      errors++;
      $display("FAIL abort_acc: lat=%0d s=%h required %h", lat, s, e.s);
    end
    consume(e.s);
    do_op(16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0, lat);
    e = sb.pop_front();
    checks++;
    if (lat < 0 || {s, cout, ovf} !== {e.s, e.co, e.ov}) begin
      errors++;
      $display("FAIL abort_next: lat=%0d s=%h required %h", lat, s, e.s);
    end
    consume(e.s);
  endtask

  task automatic test_random();
    exp_t e;
    int   lat;
    logic [W-1:0] ra, rb;
    logic [2:0]   rm;
    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rm = 3'($urandom);
      do_op(ra, rb, rm[0], rm[1], rm[2], lat);
      e = sb.pop_front();
      checks++;
      if (lat != 4 || {s, cout, ovf} !== {e.s, e.co, e.ov}) begin
        errors++;
        $display("FAIL rand[%0d]: lat=%0d s=%h co=%b ov=%b required s=%h co=%b ov=%b",
                 i, lat, s, cout, ovf, e.s, e.co, e.ov);
      end
      consume(e.s);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_acc();
    test_backpressure();
    test_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
